// File: rtl/str_arb_rr.sv
// Round-robin, packet-locked stream arbiter: NB_UP requesters share one downstream
// beat register, and a grant is held from a packet's first beat to its last.
module str_arb_rr #(
    parameter int NB_UP      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = $clog2(NB_UP)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NB_UP*DATA_WIDTH-1:0] up_data,
    input  logic [NB_UP-1:0]            up_last,
    input  logic [NB_UP-1:0]            up_val,
    output logic [NB_UP-1:0]            up_rdy,
    output logic [DATA_WIDTH-1:0]       dn_data,
    output logic                        dn_last,
    output logic [SEL_WIDTH-1:0]        dn_sel,
    output logic                        dn_val,
    input  logic                        dn_rdy
);

    typedef enum logic {ST_IDLE, ST_LOCK} state_t;

    state_t                 r_state;
    logic [SEL_WIDTH-1:0]   r_grant;
    logic [SEL_WIDTH-1:0]   r_ptr;
    logic                   r_dn_val;
    logic                   r_dn_last;
    logic [SEL_WIDTH-1:0]   r_dn_sel;
    logic [DATA_WIDTH-1:0]  r_dn_data;

    logic                   w_dn_active;
    logic                   w_accept;
    logic                   w_found;
    logic [SEL_WIDTH-1:0]   w_pick;

    function automatic logic [SEL_WIDTH-1:0] next_idx(input logic [SEL_WIDTH-1:0] idx);
        if (int'(idx) == NB_UP - 1) begin
            return '0;
        end
        return idx + SEL_WIDTH'(1);
    endfunction

    // Rotating scan starting at r_ptr; the first requester found wins.
    always_comb begin
        logic [SEL_WIDTH-1:0] v_idx;
        w_found = 1'b0;
        w_pick  = r_ptr;
        v_idx   = r_ptr;
        for (int k = 0; k < NB_UP; k++) begin
            if (!w_found && up_val[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
            v_idx = next_idx(v_idx);
        end
    end

    assign w_dn_active = ~r_dn_val | dn_rdy;
    assign w_accept    = (r_state == ST_LOCK) & w_dn_active & up_val[r_grant];

    always_comb begin
        up_rdy = '0;
        if (r_state == ST_LOCK && w_dn_active) begin
            up_rdy[r_grant] = 1'b1;
        end
    end

    // Arbitration state and downstream control register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_ptr     <= '0;
            r_dn_val  <= 1'b0;
            r_dn_last <= 1'b0;
            r_dn_sel  <= '0;
        end else begin
            if (w_dn_active) begin
                r_dn_val <= w_accept;
                if (w_accept) begin
                    r_dn_last <= up_last[r_grant];
                    r_dn_sel  <= r_grant;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    // Gaps in up_val keep the lock; only an accepted last beat releases it.
                    if (w_accept && up_last[r_grant]) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= next_idx(r_grant);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Data path register carries no reset; dn_val qualifies it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dn_data <= up_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign dn_data = r_dn_data;
    assign dn_last = r_dn_last;
    assign dn_sel  = r_dn_sel;
    assign dn_val  = r_dn_val;

endmodule

// File: tb/tb_str_arb_rr.sv
// Scoreboard bench for str_arb_rr: a rotation/lock reference model predicts grants
// and beats, and an independent monitor checks every downstream beat.
module tb_str_arb_rr;

    localparam int NB_UP = 4;
    localparam int DW    = 8;
    localparam int SW    = 2;
    localparam int IW    = SW + 1 + DW;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NB_UP*DW-1:0]   up_data;
    logic [NB_UP-1:0]      up_last;
    logic [NB_UP-1:0]      up_val;
    logic [NB_UP-1:0]      up_rdy;
    logic [DW-1:0]         dn_data;
    logic                  dn_last;
    logic [SW-1:0]         dn_sel;
    logic                  dn_val;
    logic                  dn_rdy;

    always #5 clk = ~clk;

    str_arb_rr #(.NB_UP(NB_UP), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .up_data(up_data), .up_last(up_last), .up_val(up_val), .up_rdy(up_rdy),
        .dn_data(dn_data), .dn_last(dn_last), .dn_sel(dn_sel), .dn_val(dn_val),
        .dn_rdy(dn_rdy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [IW-1:0] exp_q[$];
    int            sel_log[$];
    int            start_log[$];

    // stimulus knobs and per-port packet generator state
    int            val_pct, rdy_pct, fixed_len, stall_cnt;
    logic [NB_UP-1:0] en_mask, busy, acc_q;
    bit            stop_new;
    int            beat[NB_UP];
    int            len[NB_UP];

    // reference model: who holds the lock, who was served last
    bit            granted;
    int            cur, last_src;
    int            wait_cnt[NB_UP];

    // monitor state
    bit            prev_stall, mon_in_pkt;
    logic [IW-1:0] prev_dn, item;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            mon_in_pkt = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {dn_val, dn_sel, dn_last, dn_data}, {1'b1, prev_dn});
            if (dn_val && dn_rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: actual sel=%0d data=%0h, required none", dn_sel, dn_data);
                end else begin
                    item = exp_q.pop_front();
                    check("beat", {dn_sel, dn_last, dn_data}, item);
                end
                if (!mon_in_pkt) begin
                    sel_log.push_back(int'(dn_sel));
                    start_log.push_back(cyc);
                end
                mon_in_pkt = !dn_last;
            end
            prev_stall = dn_val && !dn_rdy;
            prev_dn    = {dn_sel, dn_last, dn_data};
        end
    end

    task automatic sample();
        logic [NB_UP-1:0] oh;
        logic dact;
        acc_q = up_val & up_rdy;
        dact  = !dn_val || dn_rdy;
        if (!granted) begin
            check("bubble_rdy", up_rdy, 0);
            if (up_val != 0) begin
                int pick;
                pick = -1;
                for (int k = 1; k <= NB_UP; k++) begin
                    int idx;
                    idx = (last_src + k) % NB_UP;
                    if (pick < 0 && up_val[idx]) pick = idx;
                end
                for (int i = 0; i < NB_UP; i++) begin
                    if (i != pick && up_val[i]) begin
                        wait_cnt[i]++;
                        check("fair_wait", wait_cnt[i] < NB_UP, 1);
                    end
                end
                wait_cnt[pick] = 0;
                cur     = pick;
                granted = 1'b1;
            end
        end else begin
            oh = '0;
            if (dact) oh[cur] = 1'b1;
            check("rdy_lock", up_rdy, oh);
            if (acc_q != 0) begin
                oh = '0;
                oh[cur] = 1'b1;
                check("no_interleave", acc_q, oh);
                exp_q.push_back({SW'(cur), up_last[cur], up_data[cur*DW +: DW]});
                if (up_last[cur]) begin
                    granted  = 1'b0;
                    last_src = cur;
                end
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NB_UP; i++) begin
            if (acc_q[i]) begin
                up_val[i] = 1'b0;
                if (up_last[i]) busy[i] = 1'b0;
                else beat[i]++;
            end
            if (!up_val[i] && en_mask[i] && !(stop_new && !busy[i]) &&
                $urandom_range(99) < val_pct) begin
                if (!busy[i]) begin
                    busy[i] = 1'b1;
                    beat[i] = 0;
                    len[i]  = (fixed_len > 0) ? fixed_len : int'($urandom_range(4, 1));
                end
                up_val[i]            = 1'b1;
                up_data[i*DW +: DW]  = DW'($urandom);
                up_last[i]           = (beat[i] == len[i] - 1);
            end
        end
        acc_q = '0;
        if (stall_cnt > 0) begin
            dn_rdy = 1'b0;
            stall_cnt--;
        end else begin
            dn_rdy = ($urandom_range(99) < rdy_pct);
        end
    endtask

    task automatic do_neg();
        @(negedge clk);
        sample();
    endtask

    task automatic do_pos();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            do_neg();
            do_pos();
        end
    endtask

    task automatic do_reset();
        do_neg();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_dn_val", dn_val, 0);
        check("rst_up_rdy", up_rdy, 0);
        check("rst_dn_last", dn_last, 0);
        check("rst_dn_sel", dn_sel, 0);
        up_val = '0; up_last = '0; busy = '0; acc_q = '0;
        dn_rdy = 1'b0; stall_cnt = 0;
        exp_q.delete();
        granted  = 1'b0;
        last_src = NB_UP - 1;
        foreach (wait_cnt[i]) wait_cnt[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done     = 1'b0;
        stop_new = 1'b1;
        en_mask  = '1;
        for (int k = 0; k < 400 && !done; k++) begin
            do_neg();
            do_pos();
            done = (busy == 0 && up_val == 0 && exp_q.size() == 0 && !dn_val);
        end
        check("drain_done", done, 1);
        stop_new = 1'b0;
    endtask

    int exp_a[5] = '{0, 1, 2, 3, 0};

    initial begin
        up_val = '0; up_last = '0; up_data = '0; dn_rdy = 1'b0;
        busy = '0; acc_q = '0; stall_cnt = 0; stop_new = 1'b0;
        granted = 1'b0; last_src = NB_UP - 1;
        foreach (wait_cnt[i]) wait_cnt[i] = 0;
        en_mask = '1; val_pct = 100; rdy_pct = 100; fixed_len = 3;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        do_reset();

        // all four ports, 3-beat packets, first beat latency then strict rotation
        sel_log.delete(); start_log.delete();
        drive();
        do_neg(); check("lat_c0_val", dn_val, 0); do_pos();
        do_neg(); check("lat_c1_val", dn_val, 0); do_pos();
        do_neg(); check("lat_c2_val", dn_val, 1); check("lat_c2_sel", dn_sel, 0); do_pos();
        run(20);
        drain();
        check("phA_npk", sel_log.size() >= 5, 1);
        for (int k = 0; k < 5; k++)
            if (k < sel_log.size()) check($sformatf("phA_sel%0d", k), sel_log[k], exp_a[k]);
        for (int k = 0; k < 4; k++)
            if (k + 1 < start_log.size())
                check($sformatf("phA_period%0d", k), start_log[k+1] - start_log[k], 4);

        // port 2 alone, back-to-back 2-beat packets with one bubble each
        sel_log.delete(); start_log.delete();
        en_mask = 4'b0100; fixed_len = 2;
        run(16);
        drain();
        check("phB_npk", sel_log.size() >= 4, 1);
        for (int k = 0; k < 4; k++)
            if (k < sel_log.size()) check($sformatf("phB_sel%0d", k), sel_log[k], 2);
        for (int k = 0; k < 3; k++)
            if (k + 1 < start_log.size())
                check($sformatf("phB_period%0d", k), start_log[k+1] - start_log[k], 3);

        // 5-cycle downstream stall in the middle of 4-beat packets
        en_mask = '1; fixed_len = 4;
        run(6);
        stall_cnt = 5;
        run(20);
        drain();

        // ports 1 and 3 with gaps inside packets
        en_mask = 4'b1010; fixed_len = 4; val_pct = 35;
        run(80);
        drain();

        // random traffic with an asynchronous reset in the middle
        en_mask = '1; fixed_len = 0; val_pct = 50; rdy_pct = 70;
        run(4000);
        do_reset();
        run(4000);
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
